shuffle_array: RTL and testbench

SHUFFLE_ARRAY -- requirements
Module: shuffle_array

---
 rtl/shuffle_array.sv | 210 +++++++++++++++++++++
 tb/tb_shuffle_array.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_array.sv
`default_nettype none
// ============================================================================
//  Module      : shuffle_array
//  Description : Key-scheduling swap loop over a 256-byte S-memory. For each
//                i in 0..255 it reads s[i], advances j by s[i] plus a key byte,
//                reads s[j], then writes the two values back swapped. One
//                memory access per cycle, six cycles per iteration.
//  Revision    : 1.0  initial release
// ============================================================================
module shuffle_array #(
   parameter int KEY_LEN = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 restart,
   input  logic [8*KEY_LEN-1:0] secret_key,
   input  logic [7:0]           q,
   output logic [7:0]           address,
   output logic [7:0]           data,
   output logic                 wren,
   output logic                 busy,
   output logic                 finish
);

   // Key byte index counter width; at least one bit so KEY_LEN=1 still works.
   localparam int            KW        = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
   localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_LEN - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD_I = 3'd1;
   localparam logic [2:0] S_CAP_I = 3'd2;
   localparam logic [2:0] S_RD_J = 3'd3;
   localparam logic [2:0] S_CAP_J = 3'd4;
   localparam logic [2:0] S_WR_I = 3'd5;
   localparam logic [2:0] S_WR_J = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   logic [2:0]    r_state;
   logic [2:0]    w_state_next;

   logic [7:0]    r_i;
   logic [7:0]    r_j;
   logic [7:0]    r_si;
   logic [7:0]    r_sj;
   logic [KW-1:0] r_kidx;

   logic [7:0]    w_i_next;
   logic [7:0]    w_j_next;
   logic [7:0]    w_si_next;
   logic [7:0]    w_sj_next;
   logic [KW-1:0] w_kidx_next;

   logic [7:0]    w_key_bytes [KEY_LEN];
   logic [7:0]    w_key_byte;
   logic [7:0]    w_j_upd;

   logic [7:0]    w_address_next;
   logic [7:0]    w_data_next;
   logic          w_wren_next;

   // Split the key into bytes; byte 0 is the most significant byte.
   generate
      for (genvar k = 0; k < KEY_LEN; k++) begin : g_key_bytes
         assign w_key_bytes[k] = secret_key[8*KEY_LEN-1-8*k -: 8];
      end
   endgenerate

   // Select key[i mod KEY_LEN] via a wrapping index instead of a modulo.
   always_comb begin
      w_key_byte = 8'h00;
      for (int k = 0; k < KEY_LEN; k++) begin
         if (r_kidx == KW'(k)) begin
            w_key_byte = w_key_bytes[k];
         end
      end
   end

   // j advance uses the read data arriving in CAP_I; 8-bit sum wraps mod 256.
   assign w_j_upd = r_j + q + w_key_byte;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; restart overrides every transition, including start.
   always_comb begin
      w_state_next = r_state;
      if (restart) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_next = start ? S_RD_I : S_IDLE;
            S_RD_I:  w_state_next = S_CAP_I;
            S_CAP_I: w_state_next = S_RD_J;
            S_RD_J:  w_state_next = S_CAP_J;
            S_CAP_J: w_state_next = S_WR_I;
            S_WR_I:  w_state_next = S_WR_J;
            S_WR_J:  w_state_next = (r_i == 8'hFF) ? S_DONE : S_RD_I;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Datapath next values: loop counters, key index and captured bytes.
   always_comb begin
      w_i_next    = r_i;
      w_j_next    = r_j;
      w_si_next   = r_si;
      w_sj_next   = r_sj;
      w_kidx_next = r_kidx;
      if (restart) begin
         w_i_next    = 8'h00;
         w_j_next    = 8'h00;
         w_kidx_next = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_i_next    = 8'h00;
               w_j_next    = 8'h00;
               w_kidx_next = '0;
            end
            S_CAP_I: begin
               w_si_next = q;
               w_j_next  = w_j_upd;
            end
            S_CAP_J: begin
               w_sj_next = q;
            end
            S_WR_J: begin
               if (r_i != 8'hFF) begin
                  w_i_next    = r_i + 8'd1;
                  w_kidx_next = (r_kidx == KIDX_LAST) ? '0 : r_kidx + KW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_i    <= 8'h00;
         r_j    <= 8'h00;
         r_si   <= 8'h00;
         r_sj   <= 8'h00;
         r_kidx <= '0;
      end else begin
         r_i    <= w_i_next;
         r_j    <= w_j_next;
         r_si   <= w_si_next;
         r_sj   <= w_sj_next;
         r_kidx <= w_kidx_next;
      end
   end

   // Memory-port values for the state being entered, so the registered
   // outputs line up with that state in the following cycle.
   always_comb begin
      w_address_next = 8'h00;
      w_data_next    = 8'h00;
      w_wren_next    = 1'b0;
      case (w_state_next)
         S_RD_I: begin
            w_address_next = w_i_next;
         end
         S_RD_J: begin
            w_address_next = w_j_next;
         end
         S_WR_I: begin
            w_address_next = r_i;
            w_data_next    = w_sj_next;
            w_wren_next    = 1'b1;
         end
         S_WR_J: begin
            w_address_next = r_j;
            w_data_next    = r_si;
            w_wren_next    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Registered memory-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         address <= 8'h00;
         data    <= 8'h00;
         wren    <= 1'b0;
      end else begin
         address <= w_address_next;
         data    <= w_data_next;
         wren    <= w_wren_next;
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign finish = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shuffle_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shuffle_array
//  Description : Self-checking bench for shuffle_array with a synchronous
//                256-byte RAM and a software key-schedule reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shuffle_array;

   localparam int KL  = 3;
   localparam int RUN = 1537;   // start cycle T -> finish in T+RUN

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            restart = 1'b0;
   logic            mem_init = 1'b0;
   logic [8*KL-1:0] secret_key = '0;
   logic [7:0]      q;
   logic [7:0]      address;
   logic [7:0]      data;
   logic            wren;
   logic            busy;
   logic            finish;

   logic [7:0]      mem [256];

   int              errors = 0;
   int              checks = 0;
   int              cyc = 0;
   bit              active = 1'b0;
   int              t_start = 0;
   logic [7:0]      model_s [256];
   logic [15:0]     exp_q [$];
   bit              chk_en = 1'b0;
   int              n_wr = 0;
   int              n_fin = 0;
   int              fin_cyc = -1;

   always #5 clk = ~clk;

   shuffle_array #(.KEY_LEN(KL)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .restart    (restart),
      .secret_key (secret_key),
      .q          (q),
      .address    (address),
      .data       (data),
      .wren       (wren),
      .busy       (busy),
      .finish     (finish)
   );

   // Synchronous S-memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (wren === 1'b1) begin
         mem[address] <= data;
      end
      q <= mem[address];
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Plain key-schedule on a snapshot of memory; records the write sequence.
   task automatic build_model();
      int         j;
      int         kb;
      logic [7:0] t;
      for (int k = 0; k < 256; k++) model_s[k] = mem[k];
      exp_q.delete();
      j = 0;
      for (int i = 0; i < 256; i++) begin
         kb = int'((secret_key >> (8 * (KL - 1 - (i % KL)))) & 24'hFF);
         j  = (j + int'(model_s[i]) + kb) % 256;
         exp_q.push_back({8'(i), model_s[j]});
         exp_q.push_back({8'(j), model_s[i]});
         t          = model_s[i];
         model_s[i] = model_s[j];
         model_s[j] = t;
      end
   endtask

   // Reference timing: a run accepted in cycle T is busy T+1..T+RUN.
   always @(posedge clk) begin
      if (rst) begin
         active = 1'b0;
         exp_q.delete();
      end else if (restart) begin
         active = 1'b0;
         exp_q.delete();
      end else if (!active && start) begin
         t_start = cyc;
         build_model();
         active = 1'b1;
      end else if (active && cyc == t_start + RUN) begin
         active = 1'b0;
      end
      cyc = cyc + 1;
   end

   // Per-cycle comparison of the DUT against the reference.
   always @(negedge clk) begin
      logic [15:0] e;
      if (chk_en) begin
         chk("busy", busy, active);
         chk("finish", finish, active && (cyc == t_start + RUN));
         if (finish === 1'b1) begin
            n_fin++;
            fin_cyc = cyc;
         end
         if (wren !== 1'b0) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               chk("unexpected write", wren, 0);
            end else begin
               e = exp_q.pop_front();
               chk("write address", address, e[15:8]);
               chk("write data", data, e[7:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   int wr0;
   int f0;
   int ts;

   task automatic begin_run(input logic [8*KL-1:0] key, input bit init);
      secret_key = key;
      if (init) begin
         mem_init = 1'b1;
         step();
         mem_init = 1'b0;
      end
      step();
      wr0   = n_wr;
      f0    = n_fin;
      start = 1'b1;
      step();
      start = 1'b0;
      ts    = t_start;
   endtask

   task automatic end_run(input string tag);
      while (cyc <= ts + RUN) step();
      step();
      chk({tag, " finish latency"}, fin_cyc - ts, RUN);
      chk({tag, " finish count"}, n_fin - f0, 1);
      chk({tag, " write count"}, n_wr - wr0, 512);
      for (int k = 0; k < 256; k++) begin
         chk($sformatf("%s final mem[%0d]", tag, k), mem[k], model_s[k]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      rst = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      chk("reset address", address, 0);
      chk("reset data", data, 0);
      chk("reset wren", wren, 0);
      chk("reset busy", busy, 0);
      chk("reset finish", finish, 0);
      rst = 1'b0;
      step();

      // Known key on identity memory: pin the model's first writes.
      begin_run(24'h000249, 1'b1);
      chk("model 000249 w0", exp_q[0], 16'h0000);
      chk("model 000249 w1", exp_q[1], 16'h0000);
      chk("model 000249 w2", exp_q[2], 16'h0103);
      chk("model 000249 w3", exp_q[3], 16'h0301);
      chk("model 000249 w4", exp_q[4], 16'h024E);
      chk("model 000249 w5", exp_q[5], 16'h4E02);
      chk("busy at T+1", busy, 1);
      end_run("key000249");

      // All-ones key: j wraps to FF on the first two iterations.
      begin_run(24'hFFFFFF, 1'b1);
      chk("model FFFFFF w0", exp_q[0], 16'h00FF);
      chk("model FFFFFF w1", exp_q[1], 16'hFF00);
      chk("model FFFFFF w2", exp_q[2], 16'h0100);
      chk("model FFFFFF w3", exp_q[3], 16'hFF01);
      end_run("keyFFFFFF");

      // Start together with restart while idle stays idle.
      start   = 1'b1;
      restart = 1'b1;
      step();
      start   = 1'b0;
      restart = 1'b0;
      chk("start+restart idle busy", busy, 0);
      step();
      chk("start+restart idle busy later", busy, 0);

      // Abort in the RD_I cycle of i=10, then a fresh run from i=0.
      begin_run(24'($urandom), 1'b1);
      while (cyc < ts + 61) step();
      chk("RD_I address at i=10", address, 10);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("busy after restart", busy, 0);
      for (int n = 0; n < 20; n++) step();
      chk("no finish after abort", n_fin - f0, 0);
      begin_run(secret_key, 1'b0);
      chk("first address after restart", address, 0);
      end_run("after-restart");

      // Start pulses mid-run and in the DONE cycle are ignored.
      begin_run(24'($urandom), 1'b1);
      while (cyc < ts + 100) step();
      start = 1'b1; step(); start = 1'b0;
      while (cyc < ts + 700) step();
      start = 1'b1; step(); start = 1'b0;
      while (cyc < ts + RUN) step();
      start = 1'b1; step(); start = 1'b0;
      end_run("ignored-start");
      chk("idle after ignored starts", busy, 0);

      // Reset in the middle of the run at i=100.
      begin_run(24'($urandom), 1'b1);
      while (cyc < ts + 601) step();
      rst = 1'b1;
      step();
      chk("mid-run rst address", address, 0);
      chk("mid-run rst data", data, 0);
      chk("mid-run rst wren", wren, 0);
      chk("mid-run rst busy", busy, 0);
      chk("mid-run rst finish", finish, 0);
      rst = 1'b0;
      for (int n = 0; n < 10; n++) step();
      chk("no finish after rst", n_fin - f0, 0);

      // Ten random keys on identity memory.
      for (int r = 0; r < 10; r++) begin
         for (int g = 0; g < int'($urandom_range(0, 4)); g++) step();
         begin_run(24'($urandom), 1'b1);
         end_run($sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
